// File: rtl/mc_cpu_if.sv
// Unified memory bus of mc_cpu: registered request side from the core,
// ready/rdata returned by the memory.
interface mc_cpu_if #(
    parameter int n = 32
);
    logic         mem_req;
    logic         mem_we;
    logic [n-1:0] mem_addr;
    logic [n-1:0] mem_wdata;
    logic         mem_ready;
    logic [n-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mc_cpu.sv
// Multicycle MIPS subset core on one stallable req/ready memory port.
// Define MC_CPU_BNE_EN to decode opcode 0x05 (bne); otherwise it halts.
module mc_cpu #(
    parameter int           n        = 32,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    mc_cpu_if.master     bus,
    output logic [n-1:0] pc,
    output logic         halted
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23,
                           OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                           F_OR = 6'h25, F_SLT = 6'h2A;

    state_t       state, state_n;
    logic [31:0]  ir;
    logic [n-1:0] mdr, a, b, aluout;
    logic [n-1:0] rf [32];

    logic [5:0]   op, funct;
    logic [4:0]   rs, rt, rd;
    logic [n-1:0] sext, sext_sh, ea, alu_y;
    logic signed [n-1:0] sa, sb;
    logic         done, funct_ok, take;
    logic         rf_we;
    logic [4:0]   rf_wa;
    logic [n-1:0] rf_wd;

    assign op      = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign funct   = ir[5:0];
    assign sext    = {{(n-16){ir[15]}}, ir[15:0]};
    assign sext_sh = {{(n-18){ir[15]}}, ir[15:0], 2'b00};
    assign ea      = a + sext;
    assign sa      = a;
    assign sb      = b;
    assign done    = bus.mem_req & bus.mem_ready;
    assign halted  = (state == S_HALT);

`ifdef MC_CPU_BNE_EN
    assign take = (op == OP_BNE) ? (a != b) : (a == b);
`else
    assign take = (a == b);
`endif

    always_comb begin
        alu_y    = '0;
        funct_ok = 1'b1;
        case (funct)
            F_ADD:   alu_y = a + b;
            F_SUB:   alu_y = a - b;
            F_AND:   alu_y = a & b;
            F_OR:    alu_y = a | b;
            F_SLT:   alu_y = {{(n-1){1'b0}}, (sa < sb)};
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        rf_we   = 1'b0;
        rf_wa   = rt;
        rf_wd   = aluout;
        case (state)
            S_FETCH:  if (done) state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_n = funct_ok ? S_EXEC : S_HALT;
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_BEQ:       state_n = S_BRANCH;
`ifdef MC_CPU_BNE_EN
                    OP_BNE:       state_n = S_BRANCH;
`endif
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JUMP;
                    default:      state_n = S_HALT;
                endcase
            end
            S_MEMADR: state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (done) state_n = S_MEMWB;
            S_MEMWB: begin
                rf_we   = 1'b1;
                rf_wd   = mdr;
                state_n = S_FETCH;
            end
            S_MEMWR:  if (done) state_n = S_FETCH;
            S_EXEC:   state_n = S_ALUWB;
            S_ALUWB: begin
                rf_we   = 1'b1;
                rf_wa   = rd;
                state_n = S_FETCH;
            end
            S_ADDIEX: state_n = S_ADDIWB;
            S_ADDIWB: begin
                rf_we   = 1'b1;
                state_n = S_FETCH;
            end
            S_BRANCH: state_n = S_FETCH;
            S_JUMP:   state_n = S_FETCH;
            default:  state_n = S_HALT;
        endcase
    end

    // Data requests are launched from MEMADR so MEMRD/MEMWR spend only the ready cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            ir            <= '0;
            mdr           <= '0;
            a             <= '0;
            b             <= '0;
            aluout        <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state <= state_n;
            if (rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
            case (state)
                S_FETCH: begin
                    if (!bus.mem_req) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= pc;
                    end else if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        ir          <= bus.mem_rdata[31:0];
                        pc          <= pc + n'(4);
                    end
                end
                S_DECODE: begin
                    a      <= rf[rs];
                    b      <= rf[rt];
                    aluout <= pc + sext_sh;
                end
                S_MEMADR: begin
                    aluout        <= ea;
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= (op == OP_SW);
                    bus.mem_addr  <= ea;
                    bus.mem_wdata <= b;
                end
                S_MEMRD: begin
                    if (done) begin
                        bus.mem_req <= 1'b0;
                        mdr         <= bus.mem_rdata;
                    end
                end
                S_MEMWR: begin
                    if (done) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                    end
                end
                S_EXEC:   aluout <= alu_y;
                S_ADDIEX: aluout <= ea;
                S_BRANCH: if (take) pc <= aluout;
                S_JUMP:   pc <= {pc[n-1:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_cpu.sv
// Scoreboard bench for mc_cpu: expected bus transactions are queued per program
// and a monitor compares them against what the memory model observes.
`timescale 1ns/1ps
module tb_mc_cpu;
    localparam int          N   = 32;
    localparam logic [31:0] RPC = 32'h100;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] pc;
    logic         halted;

    mc_cpu_if #(.n(N)) bus();

    mc_cpu #(.n(N), .RESET_PC(RPC)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.master),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          dcyc;
        int          waits;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          start;
    } act_t;

    exp_t exp_q[$];
    act_t act_q[$];

    logic [31:0] img    [256];
    logic [31:0] dmem   [256];
    logic        dvalid [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                        input int d, input int w);
        exp_t e;
        e.addr = addr; e.we = we; e.wdata = wd; e.dcyc = d; e.waits = w;
        exp_q.push_back(e);
    endtask

    task automatic ef(input logic [31:0] addr, input int d, input int w);
        push(addr, 1'b0, 32'h0, d, w);
    endtask

    task automatic ew(input logic [31:0] addr, input logic [31:0] wd, input int d, input int w);
        push(addr, 1'b1, wd, d, w);
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        img[addr[9:2]] = word;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    // Memory model: wait count for each request comes from the head of the expectation queue.
    logic        busy;
    int          wcnt;
    logic [31:0] s_addr, s_wd;
    logic        s_we;
    int          s_cyc;
    logic [7:0]  idx;
    act_t        ra;

    initial begin
        busy = 1'b0;
        wcnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (!reset) begin
                busy = 1'b0;
                for (int i = 0; i < 256; i++) dvalid[i] = 1'b0;
            end else if (!bus.mem_req) begin
                busy = 1'b0;
            end else begin
                idx = bus.mem_addr[9:2];
                if (!busy) begin
                    busy   = 1'b1;
                    wcnt   = (exp_q.size() > 0) ? exp_q[0].waits : 0;
                    s_addr = bus.mem_addr;
                    s_we   = bus.mem_we;
                    s_wd   = bus.mem_wdata;
                    s_cyc  = cyc;
                end
                if (wcnt > 0) begin
                    wcnt--;
                end else begin
                    if (s_cyc != cyc) begin
                        chk("hold_addr", bus.mem_addr, s_addr);
                        chk("hold_we", bus.mem_we, s_we);
                        chk("hold_wdata", bus.mem_wdata, s_wd);
                    end
                    bus.mem_rdata = dvalid[idx] ? dmem[idx] : img[idx];
                    if (bus.mem_we) begin
                        dmem[idx]   = bus.mem_wdata;
                        dvalid[idx] = 1'b1;
                    end
                    ra.addr  = s_addr;
                    ra.we    = s_we;
                    ra.wdata = s_wd;
                    ra.start = s_cyc;
                    act_q.push_back(ra);
                    bus.mem_ready = 1'b1;
                    busy = 1'b0;
                end
            end
        end
    end

    // Monitor: pairs each completed transfer with the next expectation.
    act_t mac;
    exp_t mex;
    int   prev_start = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (act_q.size() > 0) begin
                mac = act_q.pop_front();
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_txn: got addr=%0h we=%0b expected no request",
                             mac.addr, mac.we);
                end else begin
                    mex = exp_q.pop_front();
                    chk("txn_addr", mac.addr, mex.addr);
                    chk("txn_we", mac.we, mex.we);
                    if (mex.we) chk("txn_wdata", mac.wdata, mex.wdata);
                    if (mex.dcyc >= 0) chk("txn_gap", 64'(mac.start - prev_start), 64'(mex.dcyc));
                end
                prev_start = mac.start;
            end
        end
    end

    task automatic finish_prog(input string tag);
        int i;
        i = 0;
        while (!halted && i < 3000) begin
            @(negedge clk);
            i++;
        end
        #2;
        chk({tag, "_halted"}, halted, 1'b1);
        repeat (20) @(negedge clk);
        #2;
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_req_idle"}, bus.mem_req, 1'b0);
        chk({tag, "_still_halted"}, halted, 1'b1);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        clear_img();
    endtask

    task automatic leave_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int i;
        // Program A: addi/add/sw, stalled lw, beq taken/not taken, j, backward beq.
        clear_img();
        put(32'h100, 32'h20010005);
        put(32'h104, 32'h20020007);
        put(32'h108, 32'h00221820);
        put(32'h10C, 32'hAC030008);
        put(32'h110, 32'h8C040008);
        put(32'h114, 32'hAC04000C);
        put(32'h118, 32'h10210001);
        put(32'h120, 32'h10220005);
        put(32'h124, 32'h08000050);
        put(32'h140, 32'h1000FFFC);
        put(32'h134, 32'hFC000000);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", pc, RPC);
        ef(32'h100, -1, 0);
        ef(32'h104, 5, 0);
        ef(32'h108, 5, 0);
        ef(32'h10C, 5, 0);
        ew(32'h8, 32'hC, 3, 0);
        ef(32'h110, 2, 3);
        push(32'h8, 1'b0, 32'h0, 6, 3);
        ef(32'h114, 6, 0);
        ew(32'hC, 32'hC, 3, 0);
        ef(32'h118, 2, 0);
        ef(32'h120, 4, 0);
        ef(32'h124, 4, 0);
        ef(32'h140, 4, 0);
        ef(32'h134, 4, 0);
        leave_reset();
        @(negedge clk);
        #2;
        chk("run_halted_low", halted, 1'b0);
        finish_prog("A");

        // Program B: opcode 0x05 is bne when enabled, illegal otherwise.
        enter_reset();
        put(32'h100, 32'h20010005);
        put(32'h104, 32'h20020007);
        put(32'h108, 32'h14220001);
        put(32'h10C, 32'hFC000000);
        put(32'h110, 32'hFC000000);
        ef(32'h100, -1, 0);
        ef(32'h104, 5, 0);
        ef(32'h108, 5, 0);
`ifdef MC_CPU_BNE_EN
        ef(32'h110, 4, 0);
`endif
        leave_reset();
        finish_prog("B");

        // Program C: reset lands on a stalled store.
        enter_reset();
        put(32'h100, 32'h2009FFFF);
        put(32'h104, 32'hAC090010);
        ef(32'h100, -1, 0);
        ef(32'h104, 5, 0);
        ew(32'h10, 32'hFFFFFFFF, 3, 1000);
        leave_reset();
        i = 0;
        while (!(bus.mem_req && bus.mem_we) && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("stall_store_seen", bus.mem_req && bus.mem_we, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_req", bus.mem_req, 1'b0);
        chk("rst_mid_addr", bus.mem_addr, 32'h0);
        chk("rst_mid_pc", pc, RPC);
        chk("rst_mid_nowrite", dvalid[4], 1'b0);
        exp_q.delete();
        clear_img();
        put(32'h100, 32'hAC090010);
        put(32'h104, 32'h2006FFFF);
        put(32'h108, 32'h20070001);
        put(32'h10C, 32'h00C7282A);
        put(32'h110, 32'hAC050014);
        put(32'h114, 32'h00E64022);
        put(32'h118, 32'hAC080018);
        put(32'h11C, 32'hFC000000);
        ef(32'h100, -1, 0);
        ew(32'h10, 32'h0, 3, 0);
        ef(32'h104, 2, 0);
        ef(32'h108, 5, 0);
        ef(32'h10C, 5, 0);
        ef(32'h110, 5, 0);
        ew(32'h14, 32'h1, 3, 0);
        ef(32'h114, 2, 0);
        ef(32'h118, 5, 0);
        ew(32'h18, 32'h2, 3, 0);
        ef(32'h11C, 2, 0);
        leave_reset();
        finish_prog("C");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mc_cpu.md
Name: mc_cpu

Overview:
- Parametrised multicycle successor to the single-cycle MIPS core.
- Fetches and executes one instruction per multi-state sequence over a single unified memory port with a req/ready handshake, so instruction and data memory may stall arbitrarily.
- Self-contained block: FSM controller, register file, ALU and non-architectural registers (IR, MDR, A, B, ALUOut).
- Adds what the single-cycle core lacks: wait-state tolerance, a configurable reset vector and an illegal-instruction halt.

Parameters:
- n, 32, datapath/register width in bits (≥32; instruction word is always the low 32 bits of mem_rdata).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_req  output  1  memory transfer request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  n  byte address, word-aligned.
- mem_wdata  output  n  store data (register rt).
- mem_ready  input  1  transfer completes on the rising edge where mem_req=1 and mem_ready=1.
- mem_rdata  input  n  read data, valid in the cycle mem_ready=1.
- pc  output  n  current PC (debug).
- halted  output  1  core stopped on illegal opcode/funct.

Behaviour:
- Reset (reset=0, async):
  - state=FETCH, pc=RESET_PC.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
  - IR, MDR, A, B, ALUOut = 0; all 32 registers = 0.
- Reset asserted mid-transfer: request is dropped immediately; the memory must discard it.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered.
  - They stay stable from assertion until the completing edge.
  - mem_req deasserts the cycle after completion.
  - The FSM waits in any memory state while mem_ready=0.
  - mem_ready while mem_req=0 is ignored.
- Instruction set: R-type add/sub/and/or/slt (opcode 0), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- Arithmetic:
  - Immediates are sign-extended to n.
  - Add/sub wrap modulo 2^n; no overflow trap.
  - slt is a signed compare and writes 1 or 0.
- Register 0: reads 0; writes to it are discarded.
- States and transitions:
  - FETCH: issue read at pc. On completion: IR←rdata[31:0], pc←pc+4 → DECODE.
  - DECODE: A←rs, B←rt, ALUOut←pc+(sext(imm)<<2). Dispatch by opcode:
    - lw/sw → MEMADR; R-type → EXEC; beq → BRANCH; addi → ADDIEX; j → JUMP.
    - Any other opcode, or unsupported funct → HALT.
  - MEMADR: ALUOut←A+sext(imm). lw → MEMRD; sw → MEMWR.
  - MEMRD: read at ALUOut; MDR←rdata on completion → MEMWB.
  - MEMWB: rt←MDR → FETCH.
  - MEMWR: write B to ALUOut → FETCH on completion.
  - EXEC: ALUOut←A op B → ALUWB.
  - ALUWB: rd←ALUOut → FETCH.
  - ADDIEX: ALUOut←A+sext(imm) → ADDIWB.
  - ADDIWB: rt←ALUOut → FETCH.
  - BRANCH: if A==B then pc←ALUOut → FETCH.
  - JUMP: pc←{pc[n-1:28], IR[25:0], 2'b00} → FETCH.
  - HALT: halted=1; no further memory requests; only reset exits.
- Cycle counts at zero wait states (FETCH completes in 2 cycles: request cycle + ready cycle):
  - lw 6, sw 5, R-type 5, addi 5, beq 4, j 4.
  - Each wait cycle adds 1.
- Address wrap: pc+4 and address adds wrap modulo 2^n.
- Misaligned effective addresses are issued unmodified; alignment is the memory's responsibility.

Optional Feature:
- Macro MC_CPU_BNE_EN.
- Defined:
  - opcode 0x05 (bne) is decoded and dispatched to BRANCH.
  - Branch is taken when A!=B; timing is identical to beq.
- Undefined: opcode 0x05 is illegal → HALT with halted=1.

Test Plan:
- Reset with RESET_PC=0x100, release → first request has mem_addr=0x100, mem_we=0, mem_req=1; halted=0.
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,8($0) with zero wait states → write of 0x0000000C to address 8; sw completes 5 cycles after its fetch starts.
- lw $4,8($0) with mem_ready held low 3 cycles on both fetch and data read:
  - mem_addr/mem_we stay stable throughout the waits.
  - $4=0x0C.
  - Instruction takes 6+6=12 cycles.
- beq $1,$1,-1 at 0x10 → next fetch address is 0x10 (taken). beq $1,$2,... → next fetch at 0x14.
- Opcode 0x05 with macro undefined → halted=1 and mem_req stays 0 indefinitely. With MC_CPU_BNE_EN and $1≠$2 → branch taken.
- Assert reset during a stalled MEMWR → mem_req drops immediately, no write occurs; after release pc=RESET_PC, all registers read 0, slt $5,$6,$7 with $6=-1, $7=1 gives $5=1.
